// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester data RAM arbiter.
// Owner encoding and burst limits used by the top and the winner picker.
package ram_arbiter_pkg;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_t;

    localparam int         DEFAULT_MAX_BURST = 4;
    localparam logic [3:0] BURST_SAT         = 4'd15;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_burst_pick.sv
// Combinational winner selection for the RAM arbiter: picks the granted
// requester and computes the next owner and burst count.
module rr_burst_pick
    import ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic       req0,
    input  logic       req1,
    input  owner_t     owner,
    input  logic [3:0] burst_cnt,
    output logic       gnt0,
    output logic       gnt1,
    output owner_t     next_owner,
    output logic [3:0] next_cnt
);

    localparam logic [3:0] OWNER_LIMIT = 4'(MAX_BURST - 1);

    owner_t winner;

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        winner     = owner;
        next_owner = owner;
        next_cnt   = burst_cnt;

        if (!req0 && !req1) begin
            next_cnt = '0;
        end else begin
            // Under contention the owner keeps the slot until its burst is used up.
            if (req0 && req1) begin
                winner = (burst_cnt < OWNER_LIMIT) ? owner : other_owner(owner);
            end else begin
                winner = req0 ? OWNER_M0 : OWNER_M1;
            end

            gnt0 = (winner == OWNER_M0);
            gnt1 = (winner == OWNER_M1);

            if (winner == owner) begin
                next_cnt = (burst_cnt == BURST_SAT) ? BURST_SAT : burst_cnt + 4'd1;
            end else begin
                next_owner = winner;
                next_cnt   = '0;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the core load/store path (m0) and
// the JTAG debug port (m1); one access per cycle, read data one cycle later.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            m0_req,
    input  logic [DW/8-1:0] m0_wen,
    input  logic            m0_ren,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_busy,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic [DW/8-1:0] m1_wen,
    input  logic            m1_ren,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic [DW/8-1:0] ram_wen,
    output logic            ram_ren,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    owner_t     owner;
    owner_t     next_owner;
    logic [3:0] burst_cnt;
    logic [3:0] next_cnt;
    logic       rvalid0;
    logic       rvalid1;
    logic       rd_fire0;
    logic       rd_fire1;

    rr_burst_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .owner      (owner),
        .burst_cnt  (burst_cnt),
        .gnt0       (m0_gnt),
        .gnt1       (m1_gnt),
        .next_owner (next_owner),
        .next_cnt   (next_cnt)
    );

    // A nonzero byte enable turns the access into a write, masking any read.
    assign rd_fire0 = m0_gnt & m0_ren & ~|m0_wen;
    assign rd_fire1 = m1_gnt & m1_ren & ~|m1_wen;

    always_comb begin
        ram_wen   = '0;
        ram_ren   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (m0_gnt) begin
            ram_wen   = m0_wen;
            ram_ren   = rd_fire0;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (m1_gnt) begin
            ram_wen   = m1_wen;
            ram_ren   = rd_fire1;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner     <= OWNER_M0;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            owner     <= next_owner;
            burst_cnt <= next_cnt;
            rvalid0   <= rd_fire0;
            rvalid1   <= rd_fire1;
        end
    end

    assign m0_busy   = m0_req & ~m0_gnt;
    assign m0_rvalid = rvalid0;
    assign m1_rvalid = rvalid1;
    assign m0_rdata  = rvalid0 ? ram_rdata : '0;
    assign m1_rdata  = rvalid1 ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a small byte-writable
// synchronous RAM model behind it.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_req, m1_req;
    logic [3:0]    m0_wen, m1_wen;
    logic          m0_ren, m1_ren;
    logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_busy, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [3:0]    ram_wen;
    logic          ram_ren;
    logic [31:0]   ram_addr, ram_wdata, ram_rdata;

    logic          pre_we;
    logic [7:0]    pre_idx;
    logic [31:0]   pre_data;
    logic [31:0]   mem [0:255];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_busy(m0_busy),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM model: word-indexed, byte writes, one-cycle read latency, bench preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (ram_ren) ram_rdata <= mem[ram_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    task automatic idle_inputs();
        m0_req = 0; m0_wen = 0; m0_ren = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wen = 0; m1_ren = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        rstn = 0;
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1; pre_idx = addr[9:2]; pre_data = data;
        @(negedge clk);
        pre_we = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        pre_we = 0; pre_idx = 0; pre_data = 0;
        rstn = 0;
        #12;
        tests_run++;
        if ({m0_gnt, m1_gnt, m0_busy, m0_rvalid, m1_rvalid} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b want 00000", {m0_gnt, m1_gnt, m0_busy, m0_rvalid, m1_rvalid});
        end
        tests_run++;
        if ({m0_rdata, m1_rdata, ram_wen, ram_ren, ram_addr, ram_wdata} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_buses: rdata0=%h rdata1=%h wen=%b ren=%b addr=%h wdata=%h want all 0",
                     m0_rdata, m1_rdata, ram_wen, ram_ren, ram_addr, ram_wdata);
        end
        @(negedge clk);
        rstn = 1;
        preload(32'h10, 32'hDEADBEEF);
        preload(32'h20, 32'h11223344);
    endtask

    task automatic test_read();
        @(negedge clk);
        m0_req = 1; m0_ren = 1; m0_addr = 32'h10;
        #1;
        tests_run++;
        if (m0_gnt !== 1'b1 || ram_ren !== 1'b1 || ram_addr !== 32'h10) begin
            tests_failed++;
            $display("[TB] FAIL read_grant: gnt=%b ren=%b addr=%h want 1 1 00000010", m0_gnt, ram_ren, ram_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL read_data: rvalid0=%b rdata0=%h rvalid1=%b want 1 deadbeef 0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL read_one_shot: rvalid0=%b rdata0=%h want 0 00000000", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        m1_req = 1; m1_wen = 4'b0010; m1_addr = 32'h20; m1_wdata = 32'h0000AB00;
        #1;
        tests_run++;
        if (m1_gnt !== 1'b1 || ram_wen !== 4'b0010 || ram_ren !== 1'b0 || ram_wdata !== 32'h0000AB00) begin
            tests_failed++;
            $display("[TB] FAIL bwrite_cmd: gnt=%b wen=%b ren=%b wdata=%h want 1 0010 0 0000ab00", m1_gnt, ram_wen, ram_ren, ram_wdata);
        end
        @(negedge clk);
        idle_inputs();
        m0_req = 1; m0_ren = 1; m0_addr = 32'h20;
        #1;
        tests_run++;
        if (m1_rvalid !== 1'b0 || m0_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bwrite_no_rvalid: rvalid1=%b gnt0=%b want 0 1", m1_rvalid, m0_gnt);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1122AB44) begin
            tests_failed++;
            $display("[TB] FAIL bwrite_readback: rvalid0=%b rdata0=%h want 1 1122ab44", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_write_with_ren();
        @(negedge clk);
        m1_req = 1; m1_wen = 4'hF; m1_ren = 1; m1_addr = 32'h30; m1_wdata = 32'h5555AAAA;
        #1;
        tests_run++;
        if (ram_ren !== 1'b0 || ram_wen !== 4'hF || m1_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wren_cmd: ren=%b wen=%b gnt1=%b want 0 1111 1", ram_ren, ram_wen, m1_gnt);
        end
        @(negedge clk);
        idle_inputs();
        m0_req = 1; m0_ren = 1; m0_addr = 32'h30;
        #1;
        tests_run++;
        if (m1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL wren_no_rvalid: rvalid1=%b want 0", m1_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (m0_rdata !== 32'h5555AAAA) begin
            tests_failed++;
            $display("[TB] FAIL wren_readback: rdata0=%h want 5555aaaa", m0_rdata);
        end
    endtask

    // From reset the first M0 burst is one short: there is no takeover grant before it.
    task automatic test_fairness();
        logic [11:0] pattern;
        logic        prev_m1;
        pattern = 12'b1000_0111_1000;
        prev_m1 = 1'b0;
        pulse_reset();
        m0_req = 1; m0_ren = 1; m0_addr = 32'h10;
        m1_req = 1; m1_ren = 1; m1_addr = 32'h20;
        for (int i = 0; i < 12; i++) begin
            #1;
            tests_run++;
            if (m1_gnt !== pattern[i] || m0_gnt !== ~pattern[i] || m0_busy !== pattern[i]) begin
                tests_failed++;
                $display("[TB] FAIL fair_slot%0d: gnt0=%b gnt1=%b busy=%b want gnt1=%b", i, m0_gnt, m1_gnt, m0_busy, pattern[i]);
            end
            if (i > 0) begin
                tests_run++;
                if (m1_rvalid !== prev_m1 || m0_rvalid !== ~prev_m1) begin
                    tests_failed++;
                    $display("[TB] FAIL fair_rvalid%0d: rvalid0=%b rvalid1=%b want rvalid1=%b", i, m0_rvalid, m1_rvalid, prev_m1);
                end
            end
            prev_m1 = pattern[i];
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        pulse_reset();
        m0_req = 1;
        repeat (10) @(negedge clk);
        m1_req = 1;
        #1;
        tests_run++;
        if (m1_gnt !== 1'b1 || m0_busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL join_after10: gnt1=%b busy=%b want 1 1", m1_gnt, m0_busy);
        end
        pulse_reset();
        m0_req = 1;
        repeat (20) @(negedge clk);
        #1;
        tests_run++;
        if (dut.burst_cnt !== 4'd15 || dut.owner !== OWNER_M0) begin
            tests_failed++;
            $display("[TB] FAIL burst_saturate: burst_cnt=%0d owner=%0d want 15 0", dut.burst_cnt, dut.owner);
        end
        m1_req = 1;
        #1;
        tests_run++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL join_after20: gnt0=%b gnt1=%b want 0 1", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        m1_req = 1; m1_ren = 1; m1_addr = 32'h10;
        repeat (2) @(negedge clk);
        idle_inputs();
        m0_req = 1; m0_ren = 1; m0_addr = 32'h10;
        repeat (3) @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b1 || dut.burst_cnt !== 4'd2) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_state: rvalid0=%b burst_cnt=%0d want 1 2", m0_rvalid, dut.burst_cnt);
        end
        rstn = 0;
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || dut.owner !== OWNER_M0 || dut.burst_cnt !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: rvalid0=%b rdata0=%h owner=%0d burst_cnt=%0d want 0 0 0 0",
                     m0_rvalid, m0_rdata, dut.owner, dut.burst_cnt);
        end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        #1;
        tests_run++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_after: rvalid0=%b rvalid1=%b want 0 0", m0_rvalid, m1_rvalid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_byte_write();
        test_write_with_ren();
        test_fairness();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
